// File: rtl/e203_exu_longpwbck_mt_pkg.sv
// Shared sizing and route encoding for the multithreaded long-pipe write-back block.
package e203_exu_longpwbck_mt_pkg;

    localparam int E203_THREADS_NUM = 2;
    localparam int E203_ITAG_WIDTH  = 1;
    localparam int E203_XLEN        = 32;
    localparam int E203_RFIDX_WIDTH = 5;
    localparam int E203_PC_SIZE     = 32;

    // Destination chosen for the granted completion
    typedef enum logic [1:0] {
        ROUTE_NONE   = 2'd0,
        ROUTE_WBCK   = 2'd1,
        ROUTE_EXCP   = 2'd2,
        ROUTE_RETIRE = 2'd3
    } route_e;

endpackage

// File: rtl/e203_exu_longpwbck_rr_arb.sv
// N-way round-robin arbiter; the grant can be frozen with hold until the consumer finishes.
module e203_exu_longpwbck_rr_arb #(
    parameter int N = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    input  logic         hold,
    input  logic         advance,
    output logic [N-1:0] grant_onehot
);

    logic [N-1:0] ptr_reg;
    logic [N-1:0] held_grant_reg;
    logic         hold_reg;
    logic [N-1:0] mask;
    logic [N-1:0] masked_req;
    logic [N-1:0] rr_grant;

    // ptr_reg is one-hot on the highest-priority thread; mask keeps it and everything above
    assign mask       = ~(ptr_reg - N'(1));
    assign masked_req = req & mask;

    always_comb begin
        if (masked_req != '0) begin
            rr_grant = masked_req & (~masked_req + N'(1));
        end else begin
            rr_grant = req & (~req + N'(1));
        end
    end

    assign grant_onehot = hold_reg ? held_grant_reg : rr_grant;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_reg        <= N'(1);
            held_grant_reg <= '0;
            hold_reg       <= 1'b0;
        end else begin
            hold_reg <= hold;
            if (hold) begin
                held_grant_reg <= grant_onehot;
            end
            if (advance) begin
                ptr_reg <= {grant_onehot[N-2:0], grant_onehot[N-1]};
            end
        end
    end

endmodule

// File: rtl/e203_exu_longpwbck_mt.sv
// Per-thread one-entry completion buffers that retire in OITF order onto a shared
// regfile write-back port or the exception port.
module e203_exu_longpwbck_mt
    import e203_exu_longpwbck_mt_pkg::*;
#(
    parameter int THREADS_NUM = E203_THREADS_NUM,
    parameter int ITAG_W      = E203_ITAG_WIDTH,
    parameter int XLEN        = E203_XLEN,
    parameter int RFIDX_W     = E203_RFIDX_WIDTH,
    parameter int PC_W        = E203_PC_SIZE
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          lsu_wbck_i_valid,
    output logic                          lsu_wbck_i_ready,
    input  logic [XLEN-1:0]               lsu_wbck_i_wdat,
    input  logic [ITAG_W-1:0]             lsu_wbck_i_itag,
    input  logic [THREADS_NUM-1:0]        lsu_wbck_i_tid,
    input  logic                          lsu_wbck_i_err,
    input  logic [THREADS_NUM*ITAG_W-1:0] oitf_ret_ptr,
    input  logic [THREADS_NUM*RFIDX_W-1:0] oitf_ret_rdidx,
    input  logic [THREADS_NUM-1:0]        oitf_ret_rdwen,
    input  logic [THREADS_NUM*PC_W-1:0]   oitf_ret_pc,
    input  logic [THREADS_NUM-1:0]        oitf_empty,
    output logic [THREADS_NUM-1:0]        oitf_ret_ena,
    output logic                          longp_wbck_o_valid,
    input  logic                          longp_wbck_o_ready,
    output logic [XLEN-1:0]               longp_wbck_o_wdat,
    output logic [RFIDX_W-1:0]            longp_wbck_o_rdidx,
    output logic [THREADS_NUM-1:0]        longp_wbck_o_tid,
    output logic                          longp_excp_o_valid,
    input  logic                          longp_excp_o_ready,
    output logic [PC_W-1:0]               longp_excp_o_pc,
    output logic [THREADS_NUM-1:0]        longp_excp_o_tid
);

    logic              buf_vld_reg  [THREADS_NUM];
    logic              buf_err_reg  [THREADS_NUM];
    logic [XLEN-1:0]   buf_wdat_reg [THREADS_NUM];
    logic [ITAG_W-1:0] buf_itag_reg [THREADS_NUM];

    logic [THREADS_NUM-1:0] buf_vld;
    logic [THREADS_NUM-1:0] buf_err;
    logic [THREADS_NUM-1:0] elig;
    logic [THREADS_NUM-1:0] grant;
    logic [THREADS_NUM-1:0] drain;
    logic [THREADS_NUM-1:0] load;

    logic [XLEN-1:0]    wdat_acc  [THREADS_NUM+1];
    logic [RFIDX_W-1:0] rdidx_acc [THREADS_NUM+1];
    logic [PC_W-1:0]    pc_acc    [THREADS_NUM+1];

    logic   tid_onehot;
    logic   any_grant;
    logic   sel_err;
    logic   sel_rdwen;
    logic   wbck_valid;
    logic   excp_valid;
    logic   done;
    route_e route;

    assign wdat_acc[0]  = '0;
    assign rdidx_acc[0] = '0;
    assign pc_acc[0]    = '0;

    genvar gi;
    generate
        for (gi = 0; gi < THREADS_NUM; gi++) begin : g_thread
            assign buf_vld[gi] = buf_vld_reg[gi];
            assign buf_err[gi] = buf_err_reg[gi];
            assign elig[gi]    = buf_vld_reg[gi] & ~oitf_empty[gi]
                               & (buf_itag_reg[gi] == oitf_ret_ptr[gi*ITAG_W +: ITAG_W]);
            assign load[gi]    = lsu_wbck_i_valid & lsu_wbck_i_ready & lsu_wbck_i_tid[gi];

            // Refill takes priority so a drained slot can be reloaded on the same edge
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    buf_vld_reg[gi]  <= 1'b0;
                    buf_err_reg[gi]  <= 1'b0;
                    buf_wdat_reg[gi] <= '0;
                    buf_itag_reg[gi] <= '0;
                end else if (load[gi]) begin
                    buf_vld_reg[gi]  <= 1'b1;
                    buf_err_reg[gi]  <= lsu_wbck_i_err;
                    buf_wdat_reg[gi] <= lsu_wbck_i_wdat;
                    buf_itag_reg[gi] <= lsu_wbck_i_itag;
                end else if (drain[gi]) begin
                    buf_vld_reg[gi]  <= 1'b0;
                end
            end

            assign wdat_acc[gi+1]  = wdat_acc[gi]  | ({XLEN{grant[gi]}} & buf_wdat_reg[gi]);
            assign rdidx_acc[gi+1] = rdidx_acc[gi]
                                   | ({RFIDX_W{grant[gi]}} & oitf_ret_rdidx[gi*RFIDX_W +: RFIDX_W]);
            assign pc_acc[gi+1]    = pc_acc[gi]
                                   | ({PC_W{grant[gi]}} & oitf_ret_pc[gi*PC_W +: PC_W]);
        end
    endgenerate

    assign tid_onehot = (lsu_wbck_i_tid != '0)
                      && ((lsu_wbck_i_tid & (lsu_wbck_i_tid - THREADS_NUM'(1))) == '0);
    assign lsu_wbck_i_ready = tid_onehot & (|(lsu_wbck_i_tid & (~buf_vld | drain)));

    e203_exu_longpwbck_rr_arb #(
        .N (THREADS_NUM)
    ) u_arb (
        .clk          (clk),
        .rst_n        (rst_n),
        .req          (elig),
        .hold         (any_grant & ~done),
        .advance      (done),
        .grant_onehot (grant)
    );

    assign any_grant = |grant;
    assign sel_err   = |(grant & buf_err);
    assign sel_rdwen = |(grant & oitf_ret_rdwen);

    always_comb begin
        route = ROUTE_NONE;
        if (any_grant) begin
            if (sel_err) begin
                route = ROUTE_EXCP;
            end else if (sel_rdwen) begin
                route = ROUTE_WBCK;
            end else begin
                route = ROUTE_RETIRE;
            end
        end
    end

    assign wbck_valid = (route == ROUTE_WBCK);
    assign excp_valid = (route == ROUTE_EXCP);
    assign done       = (wbck_valid & longp_wbck_o_ready)
                      | (excp_valid & longp_excp_o_ready)
                      | (route == ROUTE_RETIRE);
    assign drain      = grant & {THREADS_NUM{done}};

    assign oitf_ret_ena       = drain;
    assign longp_wbck_o_valid = wbck_valid;
    assign longp_wbck_o_wdat  = {XLEN{wbck_valid}} & wdat_acc[THREADS_NUM];
    assign longp_wbck_o_rdidx = {RFIDX_W{wbck_valid}} & rdidx_acc[THREADS_NUM];
    assign longp_wbck_o_tid   = {THREADS_NUM{wbck_valid}} & grant;
    assign longp_excp_o_valid = excp_valid;
    assign longp_excp_o_pc    = {PC_W{excp_valid}} & pc_acc[THREADS_NUM];
    assign longp_excp_o_tid   = {THREADS_NUM{excp_valid}} & grant;

endmodule

// File: tb/tb_e203_exu_longpwbck_mt.sv
// Randomized bench: a per-thread OITF/buffer model predicts every output cycle by cycle.
module tb_e203_exu_longpwbck_mt;

    localparam int N  = 2;
    localparam int IW = 1;
    localparam int XL = 32;
    localparam int RW = 5;
    localparam int PW = 32;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            lsu_wbck_i_valid;
    logic            lsu_wbck_i_ready;
    logic [XL-1:0]   lsu_wbck_i_wdat;
    logic [IW-1:0]   lsu_wbck_i_itag;
    logic [N-1:0]    lsu_wbck_i_tid;
    logic            lsu_wbck_i_err;
    logic [N*IW-1:0] oitf_ret_ptr;
    logic [N*RW-1:0] oitf_ret_rdidx;
    logic [N-1:0]    oitf_ret_rdwen;
    logic [N*PW-1:0] oitf_ret_pc;
    logic [N-1:0]    oitf_empty;
    logic [N-1:0]    oitf_ret_ena;
    logic            longp_wbck_o_valid;
    logic            longp_wbck_o_ready;
    logic [XL-1:0]   longp_wbck_o_wdat;
    logic [RW-1:0]   longp_wbck_o_rdidx;
    logic [N-1:0]    longp_wbck_o_tid;
    logic            longp_excp_o_valid;
    logic            longp_excp_o_ready;
    logic [PW-1:0]   longp_excp_o_pc;
    logic [N-1:0]    longp_excp_o_tid;

    always #5 clk = ~clk;

    e203_exu_longpwbck_mt dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .lsu_wbck_i_valid   (lsu_wbck_i_valid),
        .lsu_wbck_i_ready   (lsu_wbck_i_ready),
        .lsu_wbck_i_wdat    (lsu_wbck_i_wdat),
        .lsu_wbck_i_itag    (lsu_wbck_i_itag),
        .lsu_wbck_i_tid     (lsu_wbck_i_tid),
        .lsu_wbck_i_err     (lsu_wbck_i_err),
        .oitf_ret_ptr       (oitf_ret_ptr),
        .oitf_ret_rdidx     (oitf_ret_rdidx),
        .oitf_ret_rdwen     (oitf_ret_rdwen),
        .oitf_ret_pc        (oitf_ret_pc),
        .oitf_empty         (oitf_empty),
        .oitf_ret_ena       (oitf_ret_ena),
        .longp_wbck_o_valid (longp_wbck_o_valid),
        .longp_wbck_o_ready (longp_wbck_o_ready),
        .longp_wbck_o_wdat  (longp_wbck_o_wdat),
        .longp_wbck_o_rdidx (longp_wbck_o_rdidx),
        .longp_wbck_o_tid   (longp_wbck_o_tid),
        .longp_excp_o_valid (longp_excp_o_valid),
        .longp_excp_o_ready (longp_excp_o_ready),
        .longp_excp_o_pc    (longp_excp_o_pc),
        .longp_excp_o_tid   (longp_excp_o_tid)
    );

    // Reference state: completion buffers, OITF heads, fairness pointer, pending grant
    bit            m_vld   [N];
    bit            m_err   [N];
    logic [XL-1:0] m_wdat  [N];
    logic [IW-1:0] m_itag  [N];
    logic [IW-1:0] o_ptr   [N];
    logic [RW-1:0] o_rdidx [N];
    bit            o_rdwen [N];
    logic [PW-1:0] o_pc    [N];
    bit            o_empty [N];
    int            next_first;
    int            pending;
    int            cycle_no;
    int            n_checks;
    int            n_errors;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cycle_no, obs, exp);
        end
    endtask

    task automatic new_head(input int t);
        o_rdidx[t] = RW'($urandom_range(0, 31));
        o_rdwen[t] = ($urandom_range(0, 3) != 0);
        o_pc[t]    = $urandom & 32'hFFFF_FFFC;
    endtask

    task automatic drive_oitf();
        for (int t = 0; t < N; t++) begin
            oitf_ret_ptr[t*IW +: IW]   = o_ptr[t];
            oitf_ret_rdidx[t*RW +: RW] = o_rdidx[t];
            oitf_ret_rdwen[t]          = o_rdwen[t];
            oitf_ret_pc[t*PW +: PW]    = o_pc[t];
            oitf_empty[t]              = o_empty[t];
        end
    endtask

    task automatic model_reset();
        for (int t = 0; t < N; t++) begin
            m_vld[t]   = 0;
            m_err[t]   = 0;
            m_wdat[t]  = '0;
            m_itag[t]  = '0;
            o_ptr[t]   = '0;
            o_empty[t] = 0;
            new_head(t);
        end
        next_first = 0;
        pending    = -1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_ready"}, 64'(lsu_wbck_i_ready), 64'(0));
        check({tag, "_ret_ena"}, 64'(oitf_ret_ena), 64'(0));
        check({tag, "_wbck_valid"}, 64'(longp_wbck_o_valid), 64'(0));
        check({tag, "_wbck_wdat"}, 64'(longp_wbck_o_wdat), 64'(0));
        check({tag, "_wbck_rdidx"}, 64'(longp_wbck_o_rdidx), 64'(0));
        check({tag, "_wbck_tid"}, 64'(longp_wbck_o_tid), 64'(0));
        check({tag, "_excp_valid"}, 64'(longp_excp_o_valid), 64'(0));
        check({tag, "_excp_pc"}, 64'(longp_excp_o_pc), 64'(0));
        check({tag, "_excp_tid"}, 64'(longp_excp_o_tid), 64'(0));
    endtask

    // Called at a negedge; leaves rst_n released at a later negedge
    task automatic do_reset(input int cycles);
        rst_n              = 1'b0;
        lsu_wbck_i_valid   = 1'b0;
        lsu_wbck_i_tid     = '0;
        longp_wbck_o_ready = 1'b0;
        longp_excp_o_ready = 1'b0;
        model_reset();
        drive_oitf();
        #1;
        check_idle("in_reset");
        repeat (cycles) @(negedge clk);
        check_idle("reset_hold");
        rst_n = 1'b1;
    endtask

    // One clock: randomize inputs, predict and compare outputs, advance the model
    task automatic step(input int rdy_pct, input bit fill);
        int            g;
        int            ti;
        int            r;
        bit            done;
        bit            tid_ok;
        bit            exp_ready;
        bit            exp_wv;
        bit            exp_ev;
        logic [XL-1:0] exp_wdat;
        logic [RW-1:0] exp_rdidx;
        logic [PW-1:0] exp_pc;
        logic [N-1:0]  exp_ret;

        for (int t = 0; t < N; t++) begin
            if (t != pending) begin
                o_empty[t] = fill ? 1'b1 : ($urandom_range(0, 9) == 0);
                if ($urandom_range(0, 9) == 0) begin
                    o_ptr[t] = o_ptr[t] + 1'b1;
                    new_head(t);
                end
            end
        end
        drive_oitf();

        r = $urandom_range(0, 19);
        if (r == 0)       lsu_wbck_i_tid = 2'b00;
        else if (r == 1)  lsu_wbck_i_tid = 2'b11;
        else if (r < 11)  lsu_wbck_i_tid = 2'b01;
        else              lsu_wbck_i_tid = 2'b10;
        tid_ok = (lsu_wbck_i_tid == 2'b01) || (lsu_wbck_i_tid == 2'b10);
        ti     = (lsu_wbck_i_tid == 2'b10) ? 1 : 0;
        lsu_wbck_i_valid   = ($urandom_range(0, 99) < 70);
        lsu_wbck_i_wdat    = $urandom;
        lsu_wbck_i_itag    = ($urandom_range(0, 3) != 0) ? o_ptr[ti] : IW'($urandom_range(0, 1));
        lsu_wbck_i_err     = ($urandom_range(0, 6) == 0);
        longp_wbck_o_ready = fill ? 1'b0 : ($urandom_range(0, 99) < rdy_pct);
        longp_excp_o_ready = fill ? 1'b0 : ($urandom_range(0, 99) < rdy_pct);
        #1;

        // Pick the thread: a stalled grant sticks, otherwise first eligible from next_first
        g = pending;
        if (g < 0) begin
            for (int k = 0; k < N; k++) begin
                int t;
                t = (next_first + k) % N;
                if (g < 0 && m_vld[t] && !o_empty[t] && m_itag[t] == o_ptr[t]) g = t;
            end
        end
        exp_wv = 0; exp_ev = 0; exp_wdat = '0; exp_rdidx = '0; exp_pc = '0; exp_ret = '0;
        done = 0;
        if (g >= 0) begin
            if (m_err[g]) begin
                exp_ev = 1;
                exp_pc = o_pc[g];
                done   = longp_excp_o_ready;
            end else if (o_rdwen[g]) begin
                exp_wv    = 1;
                exp_wdat  = m_wdat[g];
                exp_rdidx = o_rdidx[g];
                done      = longp_wbck_o_ready;
            end else begin
                done = 1;
            end
            if (done) exp_ret[g] = 1'b1;
        end
        exp_ready = tid_ok && (!m_vld[ti] || (done && g == ti));

        check(tid_ok ? "lsu_ready" : "lsu_ready_badtid", 64'(lsu_wbck_i_ready), 64'(exp_ready));
        check("ret_ena", 64'(oitf_ret_ena), 64'(exp_ret));
        check("wbck_valid", 64'(longp_wbck_o_valid), 64'(exp_wv));
        check("wbck_wdat", 64'(longp_wbck_o_wdat), 64'(exp_wdat));
        check("wbck_rdidx", 64'(longp_wbck_o_rdidx), 64'(exp_rdidx));
        check("wbck_tid", 64'(longp_wbck_o_tid), exp_wv ? 64'(1) << g : 64'(0));
        check("excp_valid", 64'(longp_excp_o_valid), 64'(exp_ev));
        check("excp_pc", 64'(longp_excp_o_pc), 64'(exp_pc));
        check("excp_tid", 64'(longp_excp_o_tid), exp_ev ? 64'(1) << g : 64'(0));

        if (g >= 0) begin
            if (done) begin
                $display("cycle %0d retire t%0d %s wdat=%h rdidx=%0d pc=%h", cycle_no, g,
                         exp_ev ? "excp" : (exp_wv ? "wbck" : "nowr"), m_wdat[g], o_rdidx[g], o_pc[g]);
                m_vld[g]   = 0;
                next_first = (g + 1) % N;
                pending    = -1;
                o_ptr[g]   = o_ptr[g] + 1'b1;
                new_head(g);
            end else begin
                pending = g;
            end
        end
        if (lsu_wbck_i_valid && exp_ready) begin
            m_vld[ti]  = 1;
            m_err[ti]  = lsu_wbck_i_err;
            m_wdat[ti] = lsu_wbck_i_wdat;
            m_itag[ti] = lsu_wbck_i_itag;
        end
        cycle_no++;
        @(negedge clk);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        cycle_no = 0;
        lsu_wbck_i_wdat = '0;
        lsu_wbck_i_itag = '0;
        lsu_wbck_i_err  = 1'b0;
        @(negedge clk);
        do_reset(3);
        for (int i = 0; i < 600; i++) step(70, 1'b0);
        for (int i = 0; i < 15; i++)  step(0, 1'b1);
        do_reset(2);
        for (int i = 0; i < 600; i++) step(30, 1'b0);
        for (int i = 0; i < 15; i++)  step(0, 1'b1);
        do_reset(2);
        for (int i = 0; i < 600; i++) step(95, 1'b0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
